// File: rtl/afe7225_spi_config_ctrl.sv
// AFE7225 SPI configuration controller.
// Walks a configuration ROM from address 0 to NUM_WORDS-1. Each 20-bit word is
// sent as a 16-bit MSB-first SPI frame (bits [15:0]). The frame is followed by
// an idle gap whose length comes from the 4-bit delay code in bits [19:16].
// All outputs come straight from flops.
module afe7225_spi_config_ctrl #(
  parameter int NUM_WORDS  = 44,   // ROM entries to send (1..64)
  parameter int SCLK_DIV   = 4,    // SCLK half-period in clock cycles (1..255)
  parameter int DELAY_UNIT = 256   // clock cycles per count of the delay code (1..65535)
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic [5:0]  o_rom_addr,
  input  logic [19:0] i_rom_data,
  output logic        o_spi_sen,
  output logic        o_spi_sclk,
  output logic        o_spi_sdata,
  output logic        o_busy,
  output logic        o_done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Compile-time constants sized to the registers they are compared against.
  localparam logic [5:0]  LAST_ADDR = 6'(NUM_WORDS - 1);
  localparam logic [7:0]  DIV_LAST  = 8'(SCLK_DIV - 1);
  localparam logic [19:0] MIN_GAP   = 20'(2 * SCLK_DIV);
  localparam logic [19:0] UNIT      = 20'(DELAY_UNIT);

  state_t      state_q,    state_d;
  logic [5:0]  rom_addr_q, rom_addr_d;
  logic        sen_q,      sen_d;
  logic        sclk_q,     sclk_d;
  logic        sdata_q,    sdata_d;
  logic        busy_q,     busy_d;
  logic        done_q,     done_d;
  logic [15:0] shreg_q,    shreg_d;     // frame being shifted; bit 15 is on the wire
  logic [19:0] gap_len_q,  gap_len_d;   // gap length for the current word, in cycles
  logic [19:0] gap_cnt_q,  gap_cnt_d;   // cycles spent in GAP so far
  logic [7:0]  div_cnt_q,  div_cnt_d;   // cycles spent in the current SCLK half-period
  logic [4:0]  bit_cnt_q,  bit_cnt_d;   // bits completed in the current frame

  // Requested delay in cycles. The largest value, 15*65535, still fits in 20 bits.
  logic [19:0] delay_prod;

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    sen_d      = sen_q;
    sclk_d     = sclk_q;
    sdata_d    = sdata_q;
    busy_d     = busy_q;
    done_d     = done_q;
    shreg_d    = shreg_q;
    gap_len_d  = gap_len_q;
    gap_cnt_d  = gap_cnt_q;
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    delay_prod = 20'(i_rom_data[19:16]) * UNIT;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          state_d    = ST_LOAD;
          rom_addr_d = 6'd0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
        end
      end

      ST_LOAD: begin
        // Capture the word. Drive SEN low and present bit 15 on the same edge.
        shreg_d   = i_rom_data[15:0];
        gap_len_d = (delay_prod > MIN_GAP) ? delay_prod : MIN_GAP;
        sen_d     = 1'b0;
        sclk_d    = 1'b0;
        sdata_d   = i_rom_data[15];
        div_cnt_d = 8'd0;
        bit_cnt_d = 5'd0;
        state_d   = ST_SHIFT;
      end

      ST_SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = 8'd0;
          if (!sclk_q) begin
            // Rising edge: the AFE samples the bit that is already on sdata.
            sclk_d = 1'b1;
          end else begin
            // Falling edge: end the frame after bit 16, otherwise present the next bit.
            sclk_d = 1'b0;
            if (bit_cnt_q == 5'd15) begin
              sen_d     = 1'b1;
              sdata_d   = 1'b0;
              bit_cnt_d = 5'd0;
              gap_cnt_d = 20'd0;
              state_d   = ST_GAP;
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
              shreg_d   = {shreg_q[14:0], 1'b0};
              sdata_d   = shreg_q[14];
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end

      ST_GAP: begin
        // GAP lasts exactly gap_len_q cycles. LOAD adds one more SEN-high cycle.
        if (gap_cnt_q == gap_len_q - 20'd1) begin
          gap_cnt_d = 20'd0;
          if (rom_addr_q == LAST_ADDR) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            rom_addr_d = rom_addr_q + 6'd1;
            state_d    = ST_LOAD;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 20'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register. Reset takes effect at once and leaves the bus idle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      rom_addr_q <= 6'd0;
      sen_q      <= 1'b1;
      sclk_q     <= 1'b0;
      sdata_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      shreg_q    <= 16'd0;
      gap_len_q  <= 20'd0;
      gap_cnt_q  <= 20'd0;
      div_cnt_q  <= 8'd0;
      bit_cnt_q  <= 5'd0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      sen_q      <= sen_d;
      sclk_q     <= sclk_d;
      sdata_q    <= sdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      shreg_q    <= shreg_d;
      gap_len_q  <= gap_len_d;
      gap_cnt_q  <= gap_cnt_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign o_rom_addr  = rom_addr_q;
  assign o_spi_sen   = sen_q;
  assign o_spi_sclk  = sclk_q;
  assign o_spi_sdata = sdata_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_afe7225_spi_config_ctrl.sv
// Testbench for afe7225_spi_config_ctrl.
// A ROM with random contents feeds the DUT. A bus monitor decodes the SPI
// frames and their timing. Each run is compared against a word-by-word
// reference built from the ROM contents.
module tb_afe7225_spi_config_ctrl;

  localparam int NW  = 44;
  localparam int DIV = 4;
  localparam int DU  = 256;
  localparam int RUN_BUDGET = 20000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  addr;
  logic [19:0] rom_data;
  logic        sen, sclk, sdata, busy, done;

  logic [19:0] rom [0:63];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[addr];

  afe7225_spi_config_ctrl #(
    .NUM_WORDS  (NW),
    .SCLK_DIV   (DIV),
    .DELAY_UNIT (DU)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .o_rom_addr  (addr),
    .i_rom_data  (rom_data),
    .o_spi_sen   (sen),
    .o_spi_sclk  (sclk),
    .o_spi_sdata (sdata),
    .o_busy      (busy),
    .o_done      (done)
  );

  // ---------------- bus monitor (samples on the falling clock edge) ----------
  int          cyc = 0;
  int          hi_cnt = 0;
  int          low_cnt = 0;
  int          nbits = 0;
  int          cur_addr = 0;
  logic [15:0] cap = '0;
  logic        prev_sen = 1'b1;
  logic        prev_sclk = 1'b0;
  logic        prev_done = 1'b0;
  int          q_val[$];
  int          q_bits[$];
  int          q_low[$];
  int          q_addr[$];
  int          q_gap[$];     // SEN-high cycles before each frame
  int          glitches = 0; // SCLK or SDATA active while SEN is high
  int          done_rises = 0;
  int          last_rise_cyc = 0;
  int          done_rise_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (sen === 1'b0) begin
      if (prev_sen) begin
        q_gap.push_back(hi_cnt);
        low_cnt  = 0;
        nbits    = 0;
        cap      = '0;
        cur_addr = int'(addr);
      end
      low_cnt++;
      if (sclk && !prev_sclk) begin
        cap = {cap[14:0], sdata};
        nbits++;
      end
    end else begin
      if (!prev_sen) begin
        q_val.push_back(int'(cap));
        q_bits.push_back(nbits);
        q_low.push_back(low_cnt);
        q_addr.push_back(cur_addr);
        hi_cnt        = 0;
        last_rise_cyc = cyc;
      end
      hi_cnt++;
      if (sclk !== 1'b0 || sdata !== 1'b0) glitches++;
    end
    if (done && !prev_done) begin
      done_rises++;
      done_rise_cyc = cyc;
    end
    prev_sen  = sen;
    prev_sclk = sclk;
    prev_done = done;
  end

  // ---------------- reference model and helpers ------------------------------
  // Idle gap that should follow the frame of word a.
  function automatic int gap_of(input int a);
    int g;
    g = int'(rom[a][19:16]) * DU;
    return (g > 2 * DIV) ? g : 2 * DIV;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse start for exactly one rising edge. Check that it was accepted.
  task automatic pulse_start(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    chk({tag, "_done_cleared"}, 32'(done), 32'd0);
  endtask

  // Wait for done with a cycle budget. Optionally pulse start during word 5.
  task automatic wait_done(input string tag, input bit inject);
    int  n;
    bit  injected;
    n = 0;
    injected = 1'b0;
    while (!(done === 1'b1) && n < RUN_BUDGET) begin
      @(negedge clk);
      n++;
      if (inject && !injected && addr == 6'd5 && sen == 1'b0 && nbits >= 3) begin
        start = 1'b1;
        injected = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
    #1;
    chk({tag, "_no_timeout"}, 32'(n < RUN_BUDGET), 32'd1);
  endtask

  // Compare every frame of a run with the ROM-derived reference.
  task automatic check_run(input string tag, input int base, input int glitch0, input int rises0);
    int n;
    int k;
    n = q_val.size() - base;
    chk({tag, "_frame_count"}, n, NW);
    for (int i = 0; i < NW && i < n; i++) begin
      k = base + i;
      chk($sformatf("%s_w%0d_addr", tag, i), q_addr[k], i);
      chk($sformatf("%s_w%0d_data", tag, i), q_val[k], 32'(rom[i][15:0]));
      chk($sformatf("%s_w%0d_bits", tag, i), q_bits[k], 16);
      chk($sformatf("%s_w%0d_sen_low", tag, i), q_low[k], 32 * DIV);
      // SEN-high time between frames is the gap plus the single LOAD cycle.
      if (i > 0)
        chk($sformatf("%s_w%0d_gap", tag, i), q_gap[k], gap_of(i - 1) + 1);
    end
    chk({tag, "_done_after_last_gap"}, done_rise_cyc - last_rise_cyc, gap_of(NW - 1));
    chk({tag, "_done_rises_once"}, done_rises - rises0, 1);
    chk({tag, "_no_glitch"}, glitches - glitch0, 0);
    chk({tag, "_end_done"}, 32'(done), 32'd1);
    chk({tag, "_end_busy"}, 32'(busy), 32'd0);
    chk({tag, "_end_sen"}, 32'(sen), 32'd1);
    chk({tag, "_end_sclk"}, 32'(sclk), 32'd0);
    chk({tag, "_end_addr"}, 32'(addr), NW - 1);
  endtask

  // Safety net in case the DUT or the bench stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence -----------------------------------------
  initial begin
    int base;
    int g0;
    int r0;
    int n;
    int sz;

    for (int a = 0; a < 64; a++)
      rom[a] = {(($urandom_range(0, 7) == 0) ? 4'd1 : 4'd0), 16'($urandom)};
    rom[0]  = 20'h00002;
    rom[2]  = 20'h30B80;
    rom[NW-1][19:16] = 4'd2;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_sen", 32'(sen), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_sdata", 32'(sdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);

    // Start on the first rising edge after reset is released, then a full run.
    // Start is pulsed again during word 5 and must be ignored.
    base = q_val.size();
    g0 = glitches;
    r0 = done_rises;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("first_start_busy", 32'(busy), 32'd1);
    chk("first_start_addr", 32'(addr), 32'd0);
    wait_done("runA", 1'b1);
    check_run("runA", base, g0, r0);

    // Restart from DONE. Every frame must be sent again identically.
    base = q_val.size();
    g0 = glitches;
    r0 = done_rises;
    pulse_start("runB");
    wait_done("runB", 1'b0);
    check_run("runB", base, g0, r0);

    // Reset during bit 9 of word 3. The frame aborts at once and does not resume.
    pulse_start("runC");
    n = 0;
    while (!(addr == 6'd3 && sen == 1'b0 && nbits == 9) && n < RUN_BUDGET) begin
      @(negedge clk);
      n++;
    end
    chk("runC_reached_w3_bit9", 32'(n < RUN_BUDGET), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_sen", 32'(sen), 32'd1);
    chk("midrst_sclk", 32'(sclk), 32'd0);
    chk("midrst_sdata", 32'(sdata), 32'd0);
    chk("midrst_addr", 32'(addr), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    g0 = glitches;
    sz = q_val.size();
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_idle_sen", 32'(sen), 32'd1);
    chk("post_rst_idle_busy", 32'(busy), 32'd0);
    chk("post_rst_idle_addr", 32'(addr), 32'd0);
    chk("post_rst_no_frames", q_val.size() - sz, 0);
    chk("post_rst_no_glitch", glitches - g0, 0);

    // A new start sends the table again from word 0.
    base = q_val.size();
    g0 = glitches;
    r0 = done_rises;
    pulse_start("runD");
    wait_done("runD", 1'b0);
    check_run("runD", base, g0, r0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/afe7225_spi_config_ctrl.md
AFE7225_SPI_CONFIG_CTRL -- requirements
Module: afe7225_spi_config_ctrl

Interface
REQ-001 Parameter NUM_WORDS, default 44: number of configuration ROM entries to send, addresses 0..NUM_WORDS-1; legal range 1..64.
REQ-002 Parameter SCLK_DIV, default 4: SPI clock half-period in i_clk cycles; legal range 1..255.
REQ-003 Parameter DELAY_UNIT, default 256: i_clk cycles per count of the per-word delay nibble; legal range 1..65535.
REQ-004 i_clk  input  1  single clock for all logic; rising-edge.
REQ-005 i_rst  input  1  asynchronous, active-high reset.
REQ-006 i_start  input  1  start request; sampled only in IDLE or DONE.
REQ-007 o_rom_addr  output  6  address to the config ROM.
REQ-008 i_rom_data  input  20  ROM word, combinational from o_rom_addr and valid in the same cycle.
REQ-009 o_spi_sen  output  1  AFE serial enable, active-low.
REQ-010 o_spi_sclk  output  1  AFE serial clock; idles low.
REQ-011 o_spi_sdata  output  1  AFE serial data, MSB first.
REQ-012 o_busy  output  1  high from the cycle after an accepted start until DONE is entered.
REQ-013 o_done  output  1  high in DONE; held until the next accepted start or reset.

Function
REQ-014 The ROM word format SHALL be: bits [15:0] form the 16-bit SPI frame (address [15:8], data [7:0]); bits [19:16] form the post-frame delay code D.
REQ-015 The state machine SHALL use the states IDLE, LOAD, SHIFT, GAP and DONE.
REQ-016 IDLE or DONE with i_start=1: next state is LOAD, o_rom_addr is set to 0, o_busy is set to 1 and o_done is cleared.
REQ-017 LOAD (1 cycle): latch i_rom_data into the shift and delay registers; next state is SHIFT.
REQ-018 On entry to SHIFT, o_spi_sen SHALL go to 0 with o_spi_sdata = frame bit 15 in the same cycle.
REQ-019 Per bit: o_spi_sclk rises SCLK_DIV cycles after the data change and falls SCLK_DIV cycles later; the next bit is presented on the falling edge; the AFE samples on the rising edge.
REQ-020 After the 16th falling edge, o_spi_sen SHALL return to 1 in the same cycle, and sdata to 0; SEN SHALL stay low for exactly 32*SCLK_DIV cycles per frame.
REQ-021 GAP: SEN stays high for max(2*SCLK_DIV, D*DELAY_UNIT) cycles.
REQ-022 At the end of GAP: if o_rom_addr = NUM_WORDS-1, enter DONE; otherwise increment o_rom_addr and enter LOAD.
REQ-023 DONE SHALL hold o_done=1, o_busy=0, SEN=1, SCLK=0 and o_rom_addr at its last value.
REQ-024 i_start while in LOAD, SHIFT or GAP SHALL be ignored, with no effect on the sequence or the outputs.
REQ-025 The delay counter SHALL be at least 20 bits wide; the bit counter SHALL be 5 bits; no counter may wrap within a legal parameter range.
REQ-026 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-027 While i_rst=1, independent of the clock: state=IDLE, o_rom_addr=0, o_spi_sen=1, o_spi_sclk=0, o_spi_sdata=0, o_busy=0, o_done=0, and all counters cleared.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately (SEN high, no further SCLK edges) and SHALL require a new i_start; no resume is allowed.
REQ-029 The first i_start SHALL be accepted on the first rising edge after i_rst deasserts.

Verification
REQ-030 Single word (NUM_WORDS=1, SCLK_DIV=4, word 0x00002): pulse i_start -> SEN low 128 cycles; 16 SCLK rising edges capture 0x0002; 8-cycle gap; o_done=1 and o_busy=0.
REQ-031 Delay code (word 0x30B80, DELAY_UNIT=256) -> frame captures 0x0B80, then SEN stays high exactly 768 cycles before the next LOAD.
REQ-032 Full table (defaults, 44-word ROM model) -> 44 frames in address order with captured values matching bits [15:0]; o_done rises once, after address 43.
REQ-033 i_start pulsed during SHIFT of word 5 -> sequence unchanged, with no restart and no glitch on SEN or SCLK.
REQ-034 Reset mid-frame (i_rst during bit 9 of word 3) -> SEN=1, SCLK=0, addr=0 within the reset; a new i_start resends from word 0.
REQ-035 Restart from DONE: i_start -> o_done clears the next cycle and all NUM_WORDS frames are resent identically.
